// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcodes,
// state encoding, ALUOp/PCSource/ALUSrcB encodings and the control bundle.
package mips_ctrl_pkg;

    // Opcode field values (IR[31:26]) understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Controller states; 13-15 are unused and recover to IDLE
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEXEC = 4'd7,
        S_RTWB   = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    // ALUOp encodings, shared with ALU_Ctrl
    localparam logic [1:0] ALUOP_LWSW  = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // PCSource mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUSrcB mux selects
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // Every datapath enable/select driven by the controller
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // True for the opcodes DECODE knows how to dispatch
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in,
// enables and mux selects out.
interface mips_multicycle_ctrl_if;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       IllegalOp;
    logic [3:0] State;

    // Controller side
    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
               ALUOp, IllegalOp, State
    );

    // Datapath side
    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
               ALUOp, IllegalOp, State
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational output decode for the multicycle controller. Outputs are a
// function of the state only, except the FETCH write enables (gated by
// MemReady) and IllegalOp (depends on the opcode in DECODE).
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    // Per-state control decode; anything not set stays 0
    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ior_d     = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_LWSW;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only capture once the instruction word is valid
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM_SL2;
                ctrl.alu_op     = ALUOP_LWSW;
                ctrl.illegal_op = !is_supported(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_LWSW;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_RTEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_RTWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BEQ: begin
                // Zero AND PCWriteCond is resolved in the datapath
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_BEQ;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_LWSW;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            default: begin
                ctrl = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-32 datapath. Holds the state
// register and next-state logic; output decoding lives in mips_ctrl_decode.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;

    // State register; reset forces IDLE immediately so every output drops
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection; memory states hold until MemReady
    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTEXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            // Opcode is held stable past DECODE, so it still selects lw/sw here
            S_MEMADR: state_next = (bus.Opcode == OP_SW) ? S_MEMWR :
                                   (bus.Opcode == OP_LW) ? S_MEMRD : S_FETCH;
            S_MEMRD:  state_next = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = bus.MemReady ? S_FETCH : S_MEMWR;
            S_RTEXEC: state_next = S_RTWB;
            S_RTWB:   state_next = S_FETCH;
            S_BEQ:    state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state     (state_reg),
        .mem_ready (bus.MemReady),
        .opcode    (bus.Opcode),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.ior_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.IllegalOp   = ctrl.illegal_op;
    assign bus.State       = state_reg;

endmodule
